// File: rtl/axi_read_burst_sched_pkg.sv
// Shared definitions for the AXI read burst scheduler and its burst splitter.
// Optional counters in the top are enabled by defining VERSAT_BURST_SCHED_PERF_EN.
package axi_read_burst_sched_pkg;

  localparam int unsigned BOUNDARY_4K = 32'd4096;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    CALC  = S_CALC,
    ADDR  = S_ADDR,
    DATA  = S_DATA,
    FLUSH = S_FLUSH
  } state_t;

  // log2 of the bus width in bytes, i.e. the width of the byte lane offset
  function automatic int calculate_AXI_OFFSET_W(input int data_w);
    int w;
    case (data_w)
      32'sd16:  w = 32'sd1;
      32'sd32:  w = 32'sd2;
      32'sd64:  w = 32'sd3;
      32'sd128: w = 32'sd4;
      32'sd256: w = 32'sd5;
      32'sd512: w = 32'sd6;
      default:  w = 32'sd2;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/axi_read_burst_sched_if.sv
// Command and AXI read-address/read-data signals of the burst scheduler.
// master = scheduler side, slave = requester plus AXI interconnect side.
interface axi_read_burst_sched_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 8,
  parameter int XFER_W     = 20
) ();

  logic [AXI_ADDR_W-1:0] cmd_addr_i;
  logic [XFER_W-1:0]     cmd_length_i;
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [AXI_ADDR_W-1:0] m_araddr_o;
  logic [LEN_W-1:0]      m_arlen_o;
  logic                  m_arvalid_o;
  logic                  m_arready_i;
  logic                  m_rvalid_i;
  logic                  m_rready_i;
  logic                  m_rlast_i;

  modport master (
    input  cmd_addr_i, cmd_length_i, cmd_valid_i,
    output cmd_ready_o,
    output m_araddr_o, m_arlen_o, m_arvalid_o,
    input  m_arready_i, m_rvalid_i, m_rready_i, m_rlast_i
  );

  modport slave (
    output cmd_addr_i, cmd_length_i, cmd_valid_i,
    input  cmd_ready_o,
    input  m_araddr_o, m_arlen_o, m_arvalid_o,
    output m_arready_i, m_rvalid_i, m_rready_i, m_rlast_i
  );

endinterface

// File: rtl/axi_read_burst_sched_burst_split_calc.sv
// Combinational burst sizing: min(remaining, 2^LEN_W, beats to the 4 KB page end)
// and the address following that burst. Shared with the write-side scheduler.
module burst_split_calc
  import axi_read_burst_sched_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 8,
  parameter int XFER_W     = 20,
  parameter int OFFSET_W   = 2
) (
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [XFER_W:0]       remaining_i,
  output logic [LEN_W:0]        burst_o,
  output logic [AXI_ADDR_W-1:0] next_addr_o
);

  localparam int CW0 = (XFER_W + 1 > LEN_W + 2) ? XFER_W + 1 : LEN_W + 2;
  localparam int CW  = (CW0 > 14) ? CW0 : 14;

  logic [12:0]   to_4k_bytes_s;
  logic [CW-1:0] to_4k_s;
  logic [CW-1:0] max_burst_s;
  logic [CW-1:0] rem_s;
  logic [CW-1:0] min_a_s;
  logic [CW-1:0] min_b_s;

  // addr_i is bus-aligned, so the byte distance to the page end divides evenly
  assign to_4k_bytes_s = 13'(BOUNDARY_4K) - {1'b0, addr_i[11:0]};
  assign to_4k_s       = CW'(to_4k_bytes_s >> OFFSET_W);
  assign max_burst_s   = {{(CW-1){1'b0}}, 1'b1} << LEN_W;
  assign rem_s         = CW'(remaining_i);

  assign min_a_s     = (rem_s < max_burst_s) ? rem_s : max_burst_s;
  assign min_b_s     = (min_a_s < to_4k_s) ? min_a_s : to_4k_s;
  assign burst_o     = (LEN_W+1)'(min_b_s);
  assign next_addr_o = addr_i + (AXI_ADDR_W'(burst_o) << OFFSET_W);

endmodule

// File: rtl/axi_read_burst_sched.sv
// Splits one byte-addressed read transfer into legal AXI bursts, one outstanding
// at a time, and drives the byte aligner controls. Optional: VERSAT_BURST_SCHED_PERF_EN.
module axi_read_burst_sched
  import axi_read_burst_sched_pkg::*;
#(
  parameter int AXI_ADDR_W   = 32,
  parameter int AXI_DATA_W   = 32,
  parameter int LEN_W        = 8,
  parameter int XFER_W       = 20,
  localparam int OFFSET_W    = calculate_AXI_OFFSET_W(AXI_DATA_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_read_burst_sched_if.master bus,
  output logic [OFFSET_W-1:0]   align_offset_o,
  output logic                  align_start_o,
  output logic                  align_burst_last_o,
  output logic                  align_transfer_last_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef VERSAT_BURST_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles_o,
  output logic [15:0]           perf_bursts_o,
  output logic [31:0]           perf_stall_o
`endif
);

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [XFER_W-1:0]     length_q, length_d;
  logic [XFER_W:0]       remaining_q, remaining_d;
  logic [LEN_W-1:0]      arlen_q, arlen_d;
  logic                  final_q, final_d;
  logic                  tlast_q, tlast_d;
  logic                  arvalid_q, arvalid_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  cmd_ready_q, cmd_ready_d;

  logic [XFER_W+1:0]     span_s;
  logic [XFER_W:0]       beats_total_s;
  logic [AXI_ADDR_W-1:0] calc_addr_s;
  logic [XFER_W:0]       calc_rem_s;
  logic [LEN_W:0]        burst_s;
  logic [AXI_ADDR_W-1:0] calc_next_s;
  logic                  rx_beat_s;
  logic                  rx_last_s;
  logic                  load_burst_s;

  assign span_s        = {2'b00, length_q} + (XFER_W+2)'(offset_q) + (XFER_W+2)'(AXI_DATA_W/8 - 1);
  assign beats_total_s = (XFER_W+1)'(span_s >> OFFSET_W);
  assign rx_beat_s     = bus.m_rvalid_i & bus.m_rready_i;
  assign rx_last_s     = rx_beat_s & bus.m_rlast_i;

  // The first burst is sized from the whole transfer, later ones from what is left
  always_comb begin
    if (state_q == CALC) begin
      calc_addr_s = addr_q;
      calc_rem_s  = beats_total_s;
    end else begin
      calc_addr_s = next_addr_q;
      calc_rem_s  = remaining_q;
    end
  end

  burst_split_calc #(
    .AXI_ADDR_W (AXI_ADDR_W),
    .LEN_W      (LEN_W),
    .XFER_W     (XFER_W),
    .OFFSET_W   (OFFSET_W)
  ) u_split (
    .addr_i      (calc_addr_s),
    .remaining_i (calc_rem_s),
    .burst_o     (burst_s),
    .next_addr_o (calc_next_s)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    next_addr_d  = next_addr_q;
    offset_d     = offset_q;
    length_d     = length_q;
    remaining_d  = remaining_q;
    arlen_d      = arlen_q;
    final_d      = final_q;
    tlast_d      = tlast_q;
    load_burst_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          addr_d   = {bus.cmd_addr_i[AXI_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          offset_d = bus.cmd_addr_i[OFFSET_W-1:0];
          length_d = bus.cmd_length_i;
          if (bus.cmd_length_i == '0) begin
            state_d = FLUSH;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        load_burst_s = 1'b1;
        state_d      = ADDR;
      end
      ADDR: begin
        if (bus.m_arready_i) begin
          tlast_d = final_q;
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        // rlast alone ends a burst; the beat count is deliberately not cross-checked
        if (rx_last_s) begin
          tlast_d = 1'b0;
          if (remaining_q == '0) begin
            state_d = FLUSH;
          end else begin
            load_burst_s = 1'b1;
            state_d      = ADDR;
          end
        end else begin
          state_d = DATA;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_burst_s) begin
      addr_d      = calc_addr_s;
      next_addr_d = calc_next_s;
      arlen_d     = LEN_W'(burst_s - (LEN_W+1)'(1));
      remaining_d = calc_rem_s - (XFER_W+1)'(burst_s);
      final_d     = (calc_rem_s == (XFER_W+1)'(burst_s));
    end else begin
      next_addr_d = next_addr_d;
    end

    arvalid_d   = (state_d == ADDR);
    start_d     = (state_d == CALC);
    done_d      = (state_d == FLUSH);
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      next_addr_q <= '0;
      offset_q    <= '0;
      length_q    <= '0;
      remaining_q <= '0;
      arlen_q     <= '0;
      final_q     <= 1'b0;
      tlast_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      offset_q    <= offset_d;
      length_q    <= length_d;
      remaining_q <= remaining_d;
      arlen_q     <= arlen_d;
      final_q     <= final_d;
      tlast_q     <= tlast_d;
      arvalid_q   <= arvalid_d;
      start_q     <= start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready_o       = cmd_ready_q;
  assign bus.m_araddr_o        = addr_q;
  assign bus.m_arlen_o         = arlen_q;
  assign bus.m_arvalid_o       = arvalid_q;
  assign align_offset_o        = offset_q;
  assign align_start_o         = start_q;
  assign align_burst_last_o    = (state_q == DATA) & rx_last_s;
  assign align_transfer_last_o = tlast_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;

`ifdef VERSAT_BURST_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_bursts_q, perf_bursts_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating activity counters, restarted by each accepted command
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_bursts_d = perf_bursts_q;
    perf_stall_d  = perf_stall_q;
    if ((state_q == IDLE) && bus.cmd_valid_i && cmd_ready_q) begin
      perf_cycles_d = '0;
      perf_bursts_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy_q && !(&perf_cycles_q)) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end else begin
        perf_cycles_d = perf_cycles_q;
      end
      if (arvalid_q && bus.m_arready_i && !(&perf_bursts_q)) begin
        perf_bursts_d = perf_bursts_q + 16'd1;
      end else begin
        perf_bursts_d = perf_bursts_q;
      end
      if ((state_q == ADDR) && !bus.m_arready_i && !(&perf_stall_q)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end else begin
        perf_stall_d = perf_stall_q;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cycles_q <= '0;
      perf_bursts_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_bursts_q <= perf_bursts_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_bursts_o = perf_bursts_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule
